// File: rtl/dlk_pkg.sv
// Shared DLK definitions: default address width, table entry layout and the "no limit" constant.
package dlk_pkg;

  localparam int DLK_AW = 32;

  localparam logic [DLK_AW-1:0] ALL_ONES = '1;

  typedef struct packed {
    logic              valid;
    logic [DLK_AW-1:0] base;
  } dlk_entry_t;

endpackage

// File: rtl/dlk_nearest_above.sv
// Combinational search for the smallest valid base strictly above a key.
// limit is all-ones and found is low when no valid base exceeds the key.
module dlk_nearest_above
  import dlk_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = DLK_AW
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] base,
  input  logic [AW-1:0]            key,
  output logic [AW-1:0]            limit,
  output logic                     found
);

  always_comb begin
    limit = {AW{1'b1}};
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (base[i] > key) && (!found || (base[i] < limit))) begin
        limit = base[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bounds_table_dlk.sv
// Circular table of live data-block bases for the DLK checker, with a
// one-cycle registered "nearest base above" lookup and bounds violation flag.
module bounds_table_dlk
  import dlk_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int AW    = DLK_AW,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             alloc_valid_i,
  input  logic [AW-1:0]    alloc_base_i,
  input  logic             free_valid_i,
  input  logic [AW-1:0]    free_base_i,
  input  logic             chk_valid_i,
  input  logic [AW-1:0]    chk_base_i,
  input  logic [AW-1:0]    chk_addr_i,
  output logic             chk_valid_o,
  output logic             chk_violation_o,
  output logic [AW-1:0]    chk_limit_o,
  output logic             evict_o,
  output logic [PTR_W:0]   count_o
);

  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][AW-1:0] base_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic [DEPTH-1:0] dup_vec;
  logic [DEPTH-1:0] free_vec;
  logic             same_base;
  logic             do_alloc;
  logic             do_free;
  logic             target_valid;
  logic             slot_reuse;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             evict_d;
  logic [CNT_W-1:0] count_d;

  logic [AW-1:0]    near_limit;
  logic             near_found;
  logic [AW-1:0]    chk_limit_d;
  logic             chk_violation_d;

  // Match vectors are built from the pre-update table; bases are unique so free_vec is one-hot.
  always_comb begin
    dup_vec  = '0;
    free_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dup_vec[i]  = valid_q[i] && (base_q[i] == alloc_base_i);
      free_vec[i] = valid_q[i] && (base_q[i] == free_base_i);
    end
  end

  // Freeing the slot we are about to overwrite cancels both the eviction and the decrement.
  always_comb begin
    same_base    = alloc_valid_i && free_valid_i && (alloc_base_i == free_base_i);
    do_alloc     = alloc_valid_i && !(|dup_vec) && !same_base;
    do_free      = free_valid_i && (|free_vec);
    target_valid = valid_q[wr_ptr_q];
    slot_reuse   = do_alloc && do_free && free_vec[wr_ptr_q];
    cnt_inc      = do_alloc && !target_valid;
    cnt_dec      = do_free && !slot_reuse;
    evict_d      = do_alloc && target_valid && !slot_reuse;
    count_d      = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  dlk_nearest_above #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_nearest (
    .valid (valid_q),
    .base  (base_q),
    .key   (chk_base_i),
    .limit (near_limit),
    .found (near_found)
  );

  always_comb begin
    chk_limit_d     = near_found ? near_limit : {AW{1'b1}};
    chk_violation_d = (chk_addr_i >= chk_limit_d) || (chk_addr_i < chk_base_i);
  end

  // Alloc is applied after free so a reused slot ends up holding the new base.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      base_q   <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      valid_q  <= '0;
      base_q   <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_free && free_vec[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (do_alloc) begin
        valid_q[wr_ptr_q] <= 1'b1;
        base_q[wr_ptr_q]  <= alloc_base_i;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_valid_o     <= 1'b0;
      chk_violation_o <= 1'b0;
      chk_limit_o     <= {AW{1'b1}};
      evict_o         <= 1'b0;
    end else if (clear_i) begin
      chk_valid_o     <= 1'b0;
      chk_violation_o <= 1'b0;
      chk_limit_o     <= {AW{1'b1}};
      evict_o         <= 1'b0;
    end else begin
      chk_valid_o <= chk_valid_i;
      evict_o     <= evict_d;
      if (chk_valid_i) begin
        chk_violation_o <= chk_violation_d;
        chk_limit_o     <= chk_limit_d;
      end
    end
  end

  assign count_o = count_q;

endmodule
